// File: rtl/tlp_tx_arb_ctrl.sv
// tlp_tx_arb_ctrl: two-requester packet arbiter for a shared TLP TX stream.
// Grants whole packets (never interleaved), round-robins between host and
// SoC, and limits back-to-back bursts when the other side is waiting.
module tlp_tx_arb_ctrl #(
  parameter int DATA_W   = 512,
  parameter int MAX_PKTS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_en,
  input  logic              soc_en,
  input  logic              host_tvalid,
  input  logic              host_tlast,
  input  logic [DATA_W-1:0] host_tdata,
  output logic              host_tready,
  input  logic              soc_tvalid,
  input  logic              soc_tlast,
  input  logic [DATA_W-1:0] soc_tdata,
  output logic              soc_tready,
  output logic              out_tvalid,
  output logic              out_tlast,
  output logic [DATA_W-1:0] out_tdata,
  input  logic              out_tready,
  output logic [1:0]        grant,
  output logic [15:0]       host_pkt_cnt,
  output logic [15:0]       soc_pkt_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, HOST = 2'd1, SOC = 2'd2} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;          // 0: host preferred, 1: soc preferred
  logic [7:0]  burst_q, burst_d;
  logic [15:0] host_cnt_q, host_cnt_d;
  logic [15:0] soc_cnt_q, soc_cnt_d;

  logic host_sel, soc_sel;
  logic host_elig, soc_elig;
  logic done, cur_elig, oth_elig, oth_valid, burst_hit;

  assign host_sel  = (state_q == HOST);
  assign soc_sel   = (state_q == SOC);
  assign host_elig = host_tvalid & host_en;
  assign soc_elig  = soc_tvalid & soc_en;

  // Granted-side view of the packet stream and the other side's request.
  // At completion the current tvalid is high by definition, so whether the
  // current requester may continue is decided by its enable.
  assign done      = out_tvalid & out_tlast & out_tready;
  assign cur_elig  = host_sel ? host_elig : soc_elig;
  assign oth_elig  = host_sel ? soc_elig : host_elig;
  assign oth_valid = host_sel ? soc_tvalid : host_tvalid;
  assign burst_hit = ({1'b0, burst_q} + 9'd1) >= 9'(MAX_PKTS);

  // Output mux: only the granted stream reaches the TX path.
  assign out_tvalid  = (host_sel & host_tvalid) | (soc_sel & soc_tvalid);
  assign out_tlast   = (host_sel & host_tlast) | (soc_sel & soc_tlast);
  assign out_tdata   = host_sel ? host_tdata : (soc_sel ? soc_tdata : '0);
  assign host_tready = host_sel & out_tready;
  assign soc_tready  = soc_sel & out_tready;
  assign grant       = {soc_sel, host_sel};
  assign busy        = |grant;
  assign host_pkt_cnt = host_cnt_q;
  assign soc_pkt_cnt  = soc_cnt_q;

  // Next-state: arbitration from IDLE, packet-boundary handover otherwise.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    host_cnt_d = host_cnt_q;
    soc_cnt_d  = soc_cnt_q;
    unique case (state_q)
      IDLE: begin
        burst_d = '0;
        if (host_elig && (!soc_elig || !ptr_q)) state_d = HOST;
        else if (soc_elig)                      state_d = SOC;
      end
      HOST, SOC: begin
        if (done) begin
          if (host_sel) host_cnt_d = host_cnt_q + 16'd1;
          else          soc_cnt_d  = soc_cnt_q + 16'd1;
          ptr_d = host_sel;
          if (oth_elig) begin
            state_d = host_sel ? SOC : HOST;
            burst_d = '0;
          end else if (cur_elig && !(burst_hit && oth_valid)) begin
            // Saturate so a long solo burst cannot wrap the counter.
            burst_d = burst_hit ? 8'(MAX_PKTS) : burst_q + 8'd1;
          end else begin
            state_d = IDLE;
            burst_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      burst_q    <= '0;
      host_cnt_q <= '0;
      soc_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      host_cnt_q <= host_cnt_d;
      soc_cnt_q  <= soc_cnt_d;
    end
  end

endmodule

// File: tb/tb_tlp_tx_arb_ctrl.sv
// Directed bench for tlp_tx_arb_ctrl (DATA_W=32, MAX_PKTS=2).
`timescale 1ns/1ps
module tb_tlp_tx_arb_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_en, soc_en;
  logic          host_tvalid, host_tlast, soc_tvalid, soc_tlast;
  logic [DW-1:0] host_tdata, soc_tdata;
  logic          host_tready, soc_tready;
  logic          out_tvalid, out_tlast, out_tready;
  logic [DW-1:0] out_tdata;
  logic [1:0]    grant;
  logic [15:0]   host_pkt_cnt, soc_pkt_cnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  tlp_tx_arb_ctrl #(.DATA_W(DW), .MAX_PKTS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_en(host_en), .soc_en(soc_en),
    .host_tvalid(host_tvalid), .host_tlast(host_tlast),
    .host_tdata(host_tdata), .host_tready(host_tready),
    .soc_tvalid(soc_tvalid), .soc_tlast(soc_tlast),
    .soc_tdata(soc_tdata), .soc_tready(soc_tready),
    .out_tvalid(out_tvalid), .out_tlast(out_tlast),
    .out_tdata(out_tdata), .out_tready(out_tready),
    .grant(grant), .host_pkt_cnt(host_pkt_cnt), .soc_pkt_cnt(soc_pkt_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_en = 0; soc_en = 0;
    host_tvalid = 0; host_tlast = 0; host_tdata = '0;
    soc_tvalid = 0; soc_tlast = 0; soc_tdata = '0;
    out_tready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    host_en = 1; host_tvalid = 1; soc_en = 1; soc_tvalid = 1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (out_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", out_tvalid); end
    checks++; if ({host_tready, soc_tready} !== 2'b00) begin errors++; $display("FAIL rst_tready: got %b want 00", {host_tready, soc_tready}); end
    checks++; if (host_pkt_cnt !== 16'd0 || soc_pkt_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %h/%h want 0/0", host_pkt_cnt, soc_pkt_cnt); end
    tick(); tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_hold_grant: got %b want 00", grant); end
    idle_inputs();
    rst_n = 1;
    tick();
  endtask

  task automatic test_host_only();
    do_reset();
    host_en = 1; host_tvalid = 1;
    #1;
    checks++; if (grant !== 2'b00 || out_tvalid !== 1'b0) begin errors++; $display("FAIL host_first_cycle: got grant %b tvalid %b want 00 0", grant, out_tvalid); end
    tick();
    for (int k = 0; k < 12; k++) begin
      host_tdata = DW'(100 + k);
      host_tlast = (k % 4 == 3);
      host_en = (k != 11);
      #1;
      checks++;
      if (grant !== 2'b01 || out_tvalid !== 1'b1 || out_tdata !== DW'(100 + k) ||
          out_tlast !== (k % 4 == 3) || host_tready !== 1'b1 || soc_tready !== 1'b0) begin
        errors++;
        $display("FAIL host_beat%0d: got g=%b v=%b d=%0d l=%b hr=%b sr=%b want g=01 v=1 d=%0d l=%b hr=1 sr=0",
                 k, grant, out_tvalid, out_tdata, out_tlast, host_tready, soc_tready, 100 + k, (k % 4 == 3));
      end
      tick();
    end
    host_tvalid = 0; host_tlast = 0;
    #1;
    checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL host_end_idle: got g=%b busy=%b want 00 0", grant, busy); end
    checks++; if (host_pkt_cnt !== 16'd3) begin errors++; $display("FAIL host_cnt: got %0d want 3", host_pkt_cnt); end
    idle_inputs();
  endtask

  task automatic test_arb_order();
    logic       src;
    logic [1:0] eg;
    do_reset();
    host_en = 1; soc_en = 1; host_tvalid = 1; soc_tvalid = 1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_idle: got %b want 00", grant); end
    tick();
    for (int i = 0; i < 6; i++) begin
      src = ((i / 2) % 2) == 1;
      host_tdata = DW'(32'hA0 + i);
      soc_tdata  = DW'(32'hB0 + i);
      host_tlast = (i % 2 == 1);
      soc_tlast  = (i % 2 == 1);
      if (i == 5) begin host_en = 0; soc_en = 0; end
      eg = src ? 2'b10 : 2'b01;
      #1;
      checks++;
      if (grant !== eg || out_tdata !== (src ? DW'(32'hB0 + i) : DW'(32'hA0 + i))) begin
        errors++;
        $display("FAIL arb_cycle%0d: got g=%b d=%h want g=%b d=%h", i, grant, out_tdata, eg,
                 src ? DW'(32'hB0 + i) : DW'(32'hA0 + i));
      end
      tick();
    end
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_end_idle: got %b want 00", grant); end
    checks++; if (host_pkt_cnt !== 16'd2 || soc_pkt_cnt !== 16'd1) begin errors++; $display("FAIL arb_cnt: got %0d/%0d want 2/1", host_pkt_cnt, soc_pkt_cnt); end
    idle_inputs();
  endtask

  task automatic test_burst_limit();
    logic [1:0] exp_g [7];
    exp_g = '{2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b00};
    do_reset();
    soc_tvalid = 1; soc_tlast = 1;
    host_tvalid = 1; host_tlast = 1;
    for (int i = 0; i < 7; i++) begin
      host_en = (i == 4);
      soc_en = (i < 5);
      #1;
      checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL burst_cycle%0d: got %b want %b", i, grant, exp_g[i]); end
      tick();
    end
    checks++; if (soc_pkt_cnt !== 16'd3 || host_pkt_cnt !== 16'd1) begin errors++; $display("FAIL burst_cnt: got soc %0d host %0d want 3 1", soc_pkt_cnt, host_pkt_cnt); end
    idle_inputs();
  endtask

  task automatic test_en_drop();
    do_reset();
    soc_en = 1; soc_tvalid = 1;
    tick();
    for (int k = 0; k < 5; k++) begin
      soc_tdata = DW'(32'hC0 + k);
      soc_tlast = (k == 4);
      if (k == 1) soc_en = 0;
      #1;
      checks++;
      if (grant !== 2'b10 || out_tvalid !== 1'b1 || out_tdata !== DW'(32'hC0 + k)) begin
        errors++;
        $display("FAIL endrop_beat%0d: got g=%b v=%b d=%h want g=10 v=1 d=%h", k, grant, out_tvalid, out_tdata, DW'(32'hC0 + k));
      end
      tick();
    end
    soc_tlast = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL endrop_regrant%0d: got %b want 00", k, grant); end
      tick();
    end
    checks++; if (soc_pkt_cnt !== 16'd1) begin errors++; $display("FAIL endrop_cnt: got %0d want 1", soc_pkt_cnt); end
    idle_inputs();
  endtask

  task automatic test_ready_toggle();
    int beat;
    do_reset();
    host_en = 1; host_tvalid = 1;
    tick();
    beat = 0;
    for (int c = 0; c < 8; c++) begin
      out_tready = (c % 2 == 1);
      host_tdata = DW'(32'hD0 + beat);
      host_tlast = (beat == 3);
      host_en = (beat != 3);
      #1;
      checks++;
      if (grant !== 2'b01 || host_tready !== out_tready || out_tdata !== DW'(32'hD0 + beat)) begin
        errors++;
        $display("FAIL toggle_cycle%0d: got g=%b hr=%b d=%h want g=01 hr=%b d=%h", c, grant, host_tready, out_tdata, out_tready, DW'(32'hD0 + beat));
      end
      if (out_tready) beat++;
      tick();
    end
    host_tvalid = 0; host_tlast = 0; out_tready = 1;
    #1;
    checks++; if (grant !== 2'b00 || host_pkt_cnt !== 16'd1) begin errors++; $display("FAIL toggle_end: got g=%b cnt=%0d want 00 1", grant, host_pkt_cnt); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    host_en = 1; host_tvalid = 1; host_tlast = 1;
    tick();
    tick();
    host_tlast = 0;
    tick();
    #1;
    checks++; if (grant !== 2'b01 || host_pkt_cnt !== 16'd1) begin errors++; $display("FAIL rmid_pre: got g=%b cnt=%0d want 01 1", grant, host_pkt_cnt); end
    rst_n = 0;
    #1;
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || out_tvalid !== 1'b0 || host_tready !== 1'b0 || host_pkt_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rmid_async: got g=%b b=%b v=%b hr=%b cnt=%0d want 00 0 0 0 0", grant, busy, out_tvalid, host_tready, host_pkt_cnt);
    end
    tick();
    rst_n = 1;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_release: got %b want 00", grant); end
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rmid_regrant: got %b want 01", grant); end
    host_tlast = 1; host_en = 0;
    tick();
    checks++; if (grant !== 2'b00 || host_pkt_cnt !== 16'd1) begin errors++; $display("FAIL rmid_done: got g=%b cnt=%0d want 00 1", grant, host_pkt_cnt); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    host_en = 1; host_tvalid = 1; host_tlast = 1;
    tick();
    repeat (65535) tick();
    checks++; if (host_pkt_cnt !== 16'hFFFF || grant !== 2'b01) begin errors++; $display("FAIL wrap_preload: got cnt=%h g=%b want ffff 01", host_pkt_cnt, grant); end
    host_en = 0;
    tick();
    checks++; if (host_pkt_cnt !== 16'h0000 || grant !== 2'b00) begin errors++; $display("FAIL wrap_zero: got cnt=%h g=%b want 0000 00", host_pkt_cnt, grant); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_host_only();
    test_arb_order();
    test_burst_limit();
    test_en_drop();
    test_ready_toggle();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
